// File: rtl/alarm_pkg.sv
// alarm_pkg: shared mode/channel encodings and width helper for the alarm manager.
package alarm_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_RING   = 2'd1,
    CH_SNOOZE = 2'd2
  } ch_state_e;

  localparam int DISP_TIME = 0;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm's IDLE/RING/SNOOZE machine with ring timeout and snooze countdown.
// Snooze state and counter exist only when ALARM_SNOOZE_EN is defined.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int TIME_W       = 32,
  parameter int SNOOZE_TICKS = 300,
  parameter int RING_TICKS   = 600
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Sec_Tick,
  input  logic              i_Enable,
  input  logic              i_Time_Set_Mode,
  input  logic              i_Dismiss_Edge,
  input  logic              i_Snooze_Edge,
  input  logic [TIME_W-1:0] i_Time,
  input  logic [TIME_W-1:0] i_Alarm_Time,
  output logic              o_Active,
  output logic              o_Snoozing
);

  localparam int RW = cnt_w(RING_TICKS - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TICKS - 1);

  ch_state_e       state_q, state_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic            match_prev_q, match_prev_d;
  logic            active_q, active_d;
  logic            match, trig;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = cnt_w(SNOOZE_TICKS - 1);
  localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_TICKS - 1);
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          snoozing_q, snoozing_d;
`else
  logic unused_snz;
  assign unused_snz = i_Snooze_Edge ^ (SNOOZE_TICKS > 0);
`endif

  // A match only triggers on its first cycle, so a dismissed alarm stays quiet for the rest of the minute.
  assign match = (i_Time == i_Alarm_Time);
  assign trig  = i_Enable & match & ~match_prev_q & ~i_Time_Set_Mode;

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    match_prev_d = match;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d    = snz_cnt_q;
`endif
    case (state_q)
      CH_IDLE: begin
        if (trig) begin
          state_d    = CH_RING;
          ring_cnt_d = '0;
        end
      end
      CH_RING: begin
        if (!i_Enable || i_Dismiss_Edge || (i_Sec_Tick && ring_cnt_q == RING_LAST)) begin
          state_d = CH_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (i_Snooze_Edge) begin
          state_d   = CH_SNOOZE;
          snz_cnt_d = SNZ_LAST;
`endif
        end else if (i_Sec_Tick) begin
          ring_cnt_d = ring_cnt_q + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      CH_SNOOZE: begin
        if (!i_Enable || i_Dismiss_Edge) begin
          state_d = CH_IDLE;
        end else if (i_Sec_Tick) begin
          if (snz_cnt_q == '0) begin
            state_d    = CH_RING;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q - SW'(1);
          end
        end
      end
`endif
      default: state_d = CH_IDLE;
    endcase
    active_d = (state_d == CH_RING);
`ifdef ALARM_SNOOZE_EN
    snoozing_d = (state_d == CH_SNOOZE);
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= CH_IDLE;
      ring_cnt_q   <= '0;
      match_prev_q <= 1'b1;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      match_prev_q <= match_prev_d;
      active_q     <= active_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      snz_cnt_q  <= '0;
      snoozing_q <= 1'b0;
    end else begin
      snz_cnt_q  <= snz_cnt_d;
      snoozing_q <= snoozing_d;
    end
  end
  assign o_Snoozing = snoozing_q;
`else
  assign o_Snoozing = 1'b0;
`endif

  assign o_Active = active_q;

endmodule

// File: rtl/alarm_manager.sv
// alarm_manager: set-mode FSM, button edge pulses and N alarm channels for the alarm clock.
// Snooze button is honoured only when ALARM_SNOOZE_EN is defined.
module alarm_manager
  import alarm_pkg::*;
#(
  parameter int N_ALARMS     = 2,
  parameter int TIME_W       = 32,
  parameter int SNOOZE_TICKS = 300,
  parameter int RING_TICKS   = 600,
  localparam int SEL_W = cnt_w(N_ALARMS - 1),
  localparam int DSP_W = cnt_w(N_ALARMS)
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Sec_Tick,
  input  logic                       i_Change_Time,
  input  logic                       i_Change_Alarm,
  input  logic [SEL_W-1:0]           i_Alarm_Sel,
  input  logic                       i_Hours_Inc,
  input  logic                       i_Minutes_Inc,
  input  logic                       i_Snooze,
  input  logic                       i_Dismiss,
  input  logic [N_ALARMS-1:0]        i_Alarm_Enable,
  input  logic [TIME_W-1:0]          i_Time,
  input  logic [N_ALARMS*TIME_W-1:0] i_Alarm_Times,
  output logic                       o_Time_Minutes_Inc,
  output logic                       o_Time_Hours_Inc,
  output logic [N_ALARMS-1:0]        o_Alarm_Minutes_Inc,
  output logic [N_ALARMS-1:0]        o_Alarm_Hours_Inc,
  output logic [DSP_W-1:0]           o_Display_Sel,
  output logic [N_ALARMS-1:0]        o_Alarm_Active,
  output logic [N_ALARMS-1:0]        o_Alarm_Snoozing,
  output logic                       o_Alarm_On,
  output logic [N_ALARMS-1:0]        o_Alarm_Enabled
);

  mode_e               mode_q, mode_d;
  logic                min_prev_q, min_prev_d, hrs_prev_q, hrs_prev_d, dis_prev_q, dis_prev_d;
  logic                min_edge, hrs_edge, dis_edge, snz_edge;
  logic [SEL_W-1:0]    sel_c;
  logic                t_min_inc_q, t_min_inc_d, t_hrs_inc_q, t_hrs_inc_d;
  logic [N_ALARMS-1:0] a_min_inc_q, a_min_inc_d, a_hrs_inc_q, a_hrs_inc_d;
  logic [DSP_W-1:0]    disp_q, disp_d;
  logic [N_ALARMS-1:0] active, snoozing;

  always_comb begin
    sel_c = i_Alarm_Sel;
    if ({1'b0, i_Alarm_Sel} >= (SEL_W + 1)'(N_ALARMS)) sel_c = SEL_W'(N_ALARMS - 1);

    if (i_Change_Time)       mode_d = MODE_SET_TIME;
    else if (i_Change_Alarm) mode_d = MODE_SET_ALARM;
    else                     mode_d = MODE_RUN;

    min_prev_d = i_Minutes_Inc;
    hrs_prev_d = i_Hours_Inc;
    dis_prev_d = i_Dismiss;
    min_edge   = i_Minutes_Inc & ~min_prev_q;
    hrs_edge   = i_Hours_Inc & ~hrs_prev_q;
    dis_edge   = i_Dismiss & ~dis_prev_q;

    t_min_inc_d = (mode_q == MODE_SET_TIME) & min_edge;
    t_hrs_inc_d = (mode_q == MODE_SET_TIME) & hrs_edge;
    a_min_inc_d = '0;
    a_hrs_inc_d = '0;
    if (mode_q == MODE_SET_ALARM) begin
      if (min_edge) a_min_inc_d = N_ALARMS'(1) << sel_c;
      if (hrs_edge) a_hrs_inc_d = N_ALARMS'(1) << sel_c;
    end

    // Display follows the mode being entered so it lines up with mode_q.
    disp_d = DSP_W'(DISP_TIME);
    if (mode_d == MODE_SET_ALARM) disp_d = DSP_W'(sel_c) + DSP_W'(1);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      mode_q      <= MODE_RUN;
      min_prev_q  <= 1'b1;
      hrs_prev_q  <= 1'b1;
      dis_prev_q  <= 1'b1;
      t_min_inc_q <= 1'b0;
      t_hrs_inc_q <= 1'b0;
      a_min_inc_q <= '0;
      a_hrs_inc_q <= '0;
      disp_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      min_prev_q  <= min_prev_d;
      hrs_prev_q  <= hrs_prev_d;
      dis_prev_q  <= dis_prev_d;
      t_min_inc_q <= t_min_inc_d;
      t_hrs_inc_q <= t_hrs_inc_d;
      a_min_inc_q <= a_min_inc_d;
      a_hrs_inc_q <= a_hrs_inc_d;
      disp_q      <= disp_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  logic snz_prev_q, snz_prev_d;
  always_comb snz_prev_d = i_Snooze;
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) snz_prev_q <= 1'b1;
    else         snz_prev_q <= snz_prev_d;
  end
  assign snz_edge = i_Snooze & ~snz_prev_q;
`else
  logic unused_snooze;
  assign unused_snooze = i_Snooze;
  assign snz_edge      = 1'b0;
`endif

  for (genvar k = 0; k < N_ALARMS; k++) begin : g_ch
    alarm_channel #(
      .TIME_W       (TIME_W),
      .SNOOZE_TICKS (SNOOZE_TICKS),
      .RING_TICKS   (RING_TICKS)
    ) u_ch (
      .i_Clk           (i_Clk),
      .i_Reset         (i_Reset),
      .i_Sec_Tick      (i_Sec_Tick),
      .i_Enable        (i_Alarm_Enable[k]),
      .i_Time_Set_Mode (mode_q == MODE_SET_TIME),
      .i_Dismiss_Edge  (dis_edge),
      .i_Snooze_Edge   (snz_edge),
      .i_Time          (i_Time),
      .i_Alarm_Time    (i_Alarm_Times[k*TIME_W +: TIME_W]),
      .o_Active        (active[k]),
      .o_Snoozing      (snoozing[k])
    );
  end

  assign o_Time_Minutes_Inc  = t_min_inc_q;
  assign o_Time_Hours_Inc    = t_hrs_inc_q;
  assign o_Alarm_Minutes_Inc = a_min_inc_q;
  assign o_Alarm_Hours_Inc   = a_hrs_inc_q;
  assign o_Display_Sel       = disp_q;
  assign o_Alarm_Active      = active;
  assign o_Alarm_Snoozing    = snoozing;
  assign o_Alarm_On          = |active;
  assign o_Alarm_Enabled     = i_Alarm_Enable;

endmodule

// File: tb/tb_alarm_manager.sv
// Bench for alarm_manager: directed scenarios plus randomized run against a behavioural model.
module tb_alarm_manager;

  localparam int N  = 2;
  localparam int TW = 16;
  localparam int ST = 3;
  localparam int RT = 4;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic          clk, rst, tick, ct, ca, sel, hinc, minc, snz, dis;
  logic [1:0]    en;
  logic [TW-1:0] tm;
  logic [2*TW-1:0] atimes;
  logic          o_tmin, o_thrs, o_on;
  logic [1:0]    o_amin, o_ahrs, o_disp, o_act, o_snzo, o_enab;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_manager #(.N_ALARMS(N), .TIME_W(TW), .SNOOZE_TICKS(ST), .RING_TICKS(RT)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Sec_Tick(tick), .i_Change_Time(ct), .i_Change_Alarm(ca),
    .i_Alarm_Sel(sel), .i_Hours_Inc(hinc), .i_Minutes_Inc(minc), .i_Snooze(snz), .i_Dismiss(dis),
    .i_Alarm_Enable(en), .i_Time(tm), .i_Alarm_Times(atimes),
    .o_Time_Minutes_Inc(o_tmin), .o_Time_Hours_Inc(o_thrs),
    .o_Alarm_Minutes_Inc(o_amin), .o_Alarm_Hours_Inc(o_ahrs), .o_Display_Sel(o_disp),
    .o_Alarm_Active(o_act), .o_Alarm_Snoozing(o_snzo), .o_Alarm_On(o_on), .o_Alarm_Enabled(o_enab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: modes 0=run 1=set time 2=set alarm; channel 0=idle 1=ring 2=snooze.
  int   m_mode;
  bit   m_min_prev, m_hrs_prev, m_snz_prev, m_dis_prev;
  int   m_st[N];
  int   m_ring_seen[N];
  int   m_snz_seen[N];
  bit   m_match_prev[N];
  logic e_tmin, e_thrs;
  logic [1:0] e_amin, e_ahrs, e_disp, e_act, e_snzo;

  task automatic model_reset();
    m_mode = 0;
    m_min_prev = 1; m_hrs_prev = 1; m_snz_prev = 1; m_dis_prev = 1;
    for (int k = 0; k < N; k++) begin
      m_st[k] = 0; m_ring_seen[k] = 0; m_snz_seen[k] = 0; m_match_prev[k] = 1;
    end
    e_tmin = 0; e_thrs = 0; e_amin = 0; e_ahrs = 0; e_disp = 0; e_act = 0; e_snzo = 0;
  endtask

  task automatic model_step();
    int nm, sel_cl;
    bit me, he, de, se, match;
    if (rst) begin
      model_reset();
      return;
    end
    nm     = ct ? 1 : (ca ? 2 : 0);
    sel_cl = (int'(sel) >= N) ? N - 1 : int'(sel);
    me = minc && !m_min_prev;
    he = hinc && !m_hrs_prev;
    de = dis && !m_dis_prev;
    se = SNZ_EN && snz && !m_snz_prev;
    e_tmin = (m_mode == 1) && me;
    e_thrs = (m_mode == 1) && he;
    e_amin = (m_mode == 2 && me) ? 2'(1 << sel_cl) : 2'b00;
    e_ahrs = (m_mode == 2 && he) ? 2'(1 << sel_cl) : 2'b00;
    e_disp = (nm == 2) ? 2'(sel_cl + 1) : 2'd0;
    for (int k = 0; k < N; k++) begin
      match = (tm == atimes[k*TW +: TW]);
      case (m_st[k])
        0: if (en[k] && match && !m_match_prev[k] && m_mode != 1) begin
             m_st[k] = 1; m_ring_seen[k] = 0;
           end
        1: if (!en[k] || de) m_st[k] = 0;
           else if (tick && m_ring_seen[k] + 1 == RT) m_st[k] = 0;
           else if (se) begin m_st[k] = 2; m_snz_seen[k] = 0; end
           else if (tick) m_ring_seen[k]++;
        default: if (!en[k] || de) m_st[k] = 0;
           else if (tick) begin
             m_snz_seen[k]++;
             if (m_snz_seen[k] == ST) begin m_st[k] = 1; m_ring_seen[k] = 0; end
           end
      endcase
      m_match_prev[k] = match;
      e_act[k]  = (m_st[k] == 1);
      e_snzo[k] = (m_st[k] == 2);
    end
    m_mode = nm;
    m_min_prev = minc; m_hrs_prev = hinc; m_snz_prev = snz; m_dis_prev = dis;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ring_now();
    tm = 16'd6; cycle();
    tm = 16'd5; cycle();
  endtask

  task automatic test_reset();
    rst = 1; tick = 0; ct = 0; ca = 0; sel = 0; hinc = 0; minc = 0; snz = 0; dis = 0;
    en = 2'b01; tm = 16'd5; atimes = {16'd7, 16'd5};
    model_reset();
    cycle(); cycle();
    rst = 0;
    n_cmp++; if (o_act !== 2'b00) begin n_bad++; $display("FAIL reset_active: got %b want 00", o_act); end
    n_cmp++; if (o_snzo !== 2'b00) begin n_bad++; $display("FAIL reset_snoozing: got %b want 00", o_snzo); end
    n_cmp++; if (o_disp !== 2'd0) begin n_bad++; $display("FAIL reset_disp: got %0d want 0", o_disp); end
    n_cmp++; if ({o_tmin, o_thrs, o_amin, o_ahrs, o_on} !== 7'd0) begin n_bad++; $display("FAIL reset_pulses: got %b want 0", {o_tmin, o_thrs, o_amin, o_ahrs, o_on}); end
    n_cmp++; if (o_enab !== 2'b01) begin n_bad++; $display("FAIL reset_enabled: got %b want 01", o_enab); end
    repeat (3) cycle();
    n_cmp++; if (o_act !== 2'b00) begin n_bad++; $display("FAIL match_at_reset: got %b want 00", o_act); end
    ring_now();
    n_cmp++; if (o_act !== 2'b01 || o_on !== 1'b1) begin n_bad++; $display("FAIL first_ring: got act=%b on=%b want 01/1", o_act, o_on); end
    dis = 1; cycle(); dis = 0;
    n_cmp++; if (o_act !== 2'b00) begin n_bad++; $display("FAIL dismiss: got %b want 00", o_act); end
    cycle();
  endtask

  task automatic test_set_modes();
    int pulses, other;
    ca = 1; sel = 1; cycle(); cycle();
    n_cmp++; if (o_disp !== 2'd2) begin n_bad++; $display("FAIL disp_alarm1: got %0d want 2", o_disp); end
    pulses = 0; other = 0;
    minc = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (o_amin == 2'b10) pulses++;
      else if (o_amin != 2'b00 || o_tmin != 1'b0) other++;
    end
    minc = 0;
    n_cmp++; if (pulses !== 1 || other !== 0) begin n_bad++; $display("FAIL alarm_min_pulse: got %0d pulses %0d stray want 1/0", pulses, other); end
    ct = 1; cycle();
    n_cmp++; if (o_disp !== 2'd0) begin n_bad++; $display("FAIL disp_time_priority: got %0d want 0", o_disp); end
    cycle();
    hinc = 1; cycle();
    n_cmp++; if (o_thrs !== 1'b1 || o_ahrs !== 2'b00) begin n_bad++; $display("FAIL time_hrs_pulse: got %b/%b want 1/00", o_thrs, o_ahrs); end
    cycle();
    n_cmp++; if (o_thrs !== 1'b0) begin n_bad++; $display("FAIL time_hrs_single: got %b want 0", o_thrs); end
    hinc = 0; ct = 0; ca = 0; sel = 0; cycle();
  endtask

  task automatic test_snooze();
    ring_now();
    n_cmp++; if (o_act !== 2'b01) begin n_bad++; $display("FAIL snz_pre_ring: got %b want 01", o_act); end
    snz = 1; cycle(); snz = 0;
`ifdef ALARM_SNOOZE_EN
    n_cmp++; if (o_snzo !== 2'b01 || o_act !== 2'b00 || o_on !== 1'b0) begin n_bad++; $display("FAIL snz_enter: got snz=%b act=%b on=%b want 01/00/0", o_snzo, o_act, o_on); end
`else
    n_cmp++; if (o_act !== 2'b01 || o_snzo !== 2'b00) begin n_bad++; $display("FAIL snz_ignored: got act=%b snz=%b want 01/00", o_act, o_snzo); end
`endif
    repeat (ST) begin tick = 1; cycle(); tick = 0; cycle(); end
    n_cmp++; if (o_act !== 2'b01 || o_snzo !== 2'b00) begin n_bad++; $display("FAIL snz_rering: got act=%b snz=%b want 01/00", o_act, o_snzo); end
    dis = 1; cycle(); dis = 0; cycle();
  endtask

  task automatic test_timeout();
    ring_now();
    repeat (RT - 1) begin tick = 1; cycle(); tick = 0; cycle(); end
    n_cmp++; if (o_act !== 2'b01) begin n_bad++; $display("FAIL timeout_early: got %b want 01", o_act); end
    tick = 1; cycle(); tick = 0;
    n_cmp++; if (o_act !== 2'b00) begin n_bad++; $display("FAIL timeout_off: got %b want 00", o_act); end
    repeat (5) cycle();
    n_cmp++; if (o_act !== 2'b00) begin n_bad++; $display("FAIL timeout_rering: got %b want 00", o_act); end
  endtask

  task automatic test_back_to_back();
    atimes = {16'd5, 16'd5}; en = 2'b11;
    ring_now();
    n_cmp++; if (o_act !== 2'b11) begin n_bad++; $display("FAIL both_ring: got %b want 11", o_act); end
    snz = 1; dis = 1; cycle(); snz = 0; dis = 0;
    n_cmp++; if (o_act !== 2'b00 || o_snzo !== 2'b00 || o_on !== 1'b0) begin n_bad++; $display("FAIL dismiss_beats_snooze: got act=%b snz=%b on=%b want 00/00/0", o_act, o_snzo, o_on); end
    cycle();
  endtask

  task automatic test_disable_snooze();
    ring_now();
    snz = 1; cycle(); snz = 0;
`ifdef ALARM_SNOOZE_EN
    n_cmp++; if (o_snzo !== 2'b11) begin n_bad++; $display("FAIL both_snooze: got %b want 11", o_snzo); end
`else
    n_cmp++; if (o_act !== 2'b11) begin n_bad++; $display("FAIL ring_persists: got %b want 11", o_act); end
`endif
    en = 2'b01; cycle();
    n_cmp++; if ({o_act[1], o_snzo[1]} !== 2'b00 || o_enab !== 2'b01) begin n_bad++; $display("FAIL disable_ch1: got act1=%b snz1=%b enab=%b want 0/0/01", o_act[1], o_snzo[1], o_enab); end
    en = 2'b11; dis = 1; cycle(); dis = 0; cycle();
    n_cmp++; if (o_act !== 2'b00) begin n_bad++; $display("FAIL disable_cleanup: got %b want 00", o_act); end
  endtask

  task automatic test_async_reset();
    ring_now();
    n_cmp++; if (o_act !== 2'b11) begin n_bad++; $display("FAIL pre_reset_ring: got %b want 11", o_act); end
    #2 rst = 1;
    #1;
    n_cmp++; if (o_act !== 2'b00 || o_on !== 1'b0) begin n_bad++; $display("FAIL async_reset: got act=%b on=%b want 00/0", o_act, o_on); end
    cycle(); rst = 0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) tm = 16'($urandom_range(3, 6));
      if ($urandom_range(0, 7) == 0) minc = ~minc;
      if ($urandom_range(0, 7) == 0) hinc = ~hinc;
      if ($urandom_range(0, 7) == 0) snz = ~snz;
      if ($urandom_range(0, 15) == 0) dis = ~dis;
      if (ct) begin if ($urandom_range(0, 9) == 0) ct = 0; end
      else if ($urandom_range(0, 79) == 0) ct = 1;
      if (ca) begin if ($urandom_range(0, 9) == 0) ca = 0; end
      else if ($urandom_range(0, 39) == 0) ca = 1;
      if ($urandom_range(0, 9) == 0) sel = ~sel;
      if ($urandom_range(0, 49) == 0) en = en ^ 2'(1 << $urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) atimes = {16'($urandom_range(3, 6)), 16'($urandom_range(3, 6))};
      cycle();
      n_cmp++; if (o_act !== e_act) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_active@%0d: got %b want %b", i, o_act, e_act); end
      n_cmp++; if (o_snzo !== e_snzo) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_snoozing@%0d: got %b want %b", i, o_snzo, e_snzo); end
      n_cmp++; if (o_on !== (|e_act)) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_on@%0d: got %b want %b", i, o_on, |e_act); end
      n_cmp++; if (o_disp !== e_disp) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_disp@%0d: got %0d want %0d", i, o_disp, e_disp); end
      n_cmp++; if ({o_tmin, o_thrs} !== {e_tmin, e_thrs}) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_time_inc@%0d: got %b want %b", i, {o_tmin, o_thrs}, {e_tmin, e_thrs}); end
      n_cmp++; if ({o_amin, o_ahrs} !== {e_amin, e_ahrs}) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_alarm_inc@%0d: got %b want %b", i, {o_amin, o_ahrs}, {e_amin, e_ahrs}); end
      n_cmp++; if (o_enab !== en) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_enabled@%0d: got %b want %b", i, o_enab, en); end
    end
  endtask

  initial begin
    test_reset();
    test_set_modes();
    test_snooze();
    test_timeout();
    test_back_to_back();
    test_disable_snooze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
